systema_ram_loader: RTL and testbench
=====================================

# systema_ram_loader

Byte-stream-to-memory loader sitting directly upstream of the 1024×32 on-chip RAM slave. Accepts an 8-bit valid/ready byte stream (e.g. from a UART receiver), packs bytes little-endian into 32-bit words, and issues single-cycle Avalon-MM writes with byteenable into the RAM's s1 port, starting at a software-supplied word address. Used to load program/data images into RAM at run time.

## Interface
Parameters:
- ADDR_W, 10, RAM word-address width; address wraps mod 2^ADDR_W
- CNT_W, 11, width of word_count (ADDR_W+1)

Ports:
- clk  in  1  single clock for all logic
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a load (ignored while busy)
- start_addr  in  ADDR_W  first RAM word address, sampled on start
- in_data  in  8  stream byte
- in_valid  in  1  byte valid
- in_eop  in  1  marks final byte of image, qualified by in_valid
- in_ready  out  1  loader accepts byte this cycle
- mem_ready  in  1  RAM accepts write this cycle (tie to clken & ~reset_req)
- address  out  ADDR_W  RAM word address
- byteenable  out  4  lanes valid in writedata
- chipselect  out  1  write request strobe
- write  out  1  write request (equal to chipselect)
- writedata  out  32  packed word
- busy  out  1  load in progress
- done  out  1  one-cycle pulse when load completes
- word_count  out  CNT_W  words written in current/last load
- wrapped  out  1  sticky: address wrapped past 2^ADDR_W−1 during load

## Operation
- Reset values: all outputs 0; state IDLE; lane counter 0.
- States: IDLE, FILL, WRITE.
- IDLE: in_ready=0. On start: address←start_addr, lane←0, byteenable←0, word_count←0, wrapped←0, busy←1, → FILL.
- FILL: in_ready=1. Byte accepted when in_valid&in_ready: writedata[8·lane+:8]←in_data, byteenable[lane]←1, lane←lane+1. If lane==3 or in_eop: → WRITE, latch last←in_eop.
- WRITE: in_ready=0, chipselect=write=1; address/byteenable/writedata held stable. When mem_ready=1: word_count+1, address+1 (wrap 2^ADDR_W−1→0 sets wrapped), lane←0, byteenable←0, writedata←0; if last → IDLE, busy←0, done←1 for one cycle; else → FILL.
- Partial final word: in_eop on lane n gives byteenable with bits 0..n set (e.g. lane 1 → 4'b0011); unused lanes of writedata are 0.
- start while busy: ignored, no state change.
- word_count saturates at 2^CNT_W−1; wrapped stays set until next start.
- Reset asserted mid-load: immediate return to reset values; partially packed word discarded, no write issued.

## Timing
- All outputs registered.
- Bytes accepted back-to-back in FILL: one per cycle.
- Byte 4 (or eop byte) accepted at edge k → chipselect/write high from edge k to edge of first mem_ready=1 cycle; minimum one cycle.
- Throughput with mem_ready=1: 5 cycles per full word.
- done asserted the cycle after the final write is accepted; busy falls same edge.
- Next start accepted the cycle done is high (state already IDLE).

## Structure
- Shared package systema_pkg: state enum (IDLE, FILL, WRITE), LANES=4, byte width 8.
- Single module; no sub-module needed (packing and address counter are small). Optional sub-module systema_byte_packer only if reused by a future DMA.

## Test plan
- Start at addr 0x010, stream 8 bytes 0x01..0x08 with eop on last, mem_ready=1 → writes 0x04030201 @0x010 and 0x08070605 @0x011, byteenable 4'hF, word_count=2, done pulse, wrapped=0.
- Stream 6 bytes 0xA0..0xA5, eop on 6th → second write 0x0000A5A4, byteenable 4'b0011, word_count=2.
- Start at 0x3FF, 8 bytes → writes @0x3FF then @0x000, wrapped=1.
- Hold mem_ready=0 for 3 cycles during first write → address/writedata/byteenable stable, in_ready=0, single write accepted, no byte lost.
- Pulse start while busy with start_addr=0x200 → ignored, load continues at original address.
- Assert reset_n=0 after 2 bytes of a load → all outputs 0 immediately; no write issued; subsequent start loads normally.

Source files
------------

// File: rtl/systema_pkg.sv
// Shared definitions for the byte-stream RAM loader: FSM states, lane geometry
// and a small lane-mask helper.
package systema_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    localparam int LANES  = 4;
    localparam int BYTE_W = 8;
    localparam int LANE_W = 2;

    // One-hot byteenable bit for a given byte lane.
    function automatic logic [LANES-1:0] lane_mask(input logic [LANE_W-1:0] lane);
        lane_mask = 4'b0001 << lane;
    endfunction

endpackage : systema_pkg

// File: rtl/systema_ram_loader.sv
// Byte-stream-to-RAM loader: packs an 8-bit valid/ready stream little-endian
// into 32-bit words and writes them to an Avalon-MM RAM port with byteenable,
// starting at a software-supplied word address. All outputs are registered.
module systema_ram_loader
    import systema_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 11
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_eop,
    output logic              in_ready,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] address,
    output logic [3:0]        byteenable,
    output logic              chipselect,
    output logic              write,
    output logic [31:0]       writedata,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  word_count,
    output logic              wrapped
);

    state_t              state_r;
    state_t              next_state_s;
    logic                load_s;
    logic                accept_s;
    logic                write_ack_s;

    logic [LANE_W-1:0]   lane_r;
    logic                last_r;
    logic                in_ready_r;
    logic [ADDR_W-1:0]   address_r;
    logic [3:0]          byteenable_r;
    logic                chipselect_r;
    logic [31:0]         writedata_r;
    logic                busy_r;
    logic                done_r;
    logic [CNT_W-1:0]    word_count_r;
    logic                wrapped_r;

    // Next-state logic and the three datapath events (load, byte accept, write accept).
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        accept_s     = 1'b0;
        write_ack_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    load_s       = 1'b1;
                    next_state_s = ST_FILL;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (in_valid) begin
                    accept_s = 1'b1;
                    if ((lane_r == 2'd3) || in_eop) begin
                        next_state_s = ST_WRITE;
                    end else begin
                        next_state_s = ST_FILL;
                    end
                end else begin
                    next_state_s = ST_FILL;
                end
            end
            ST_WRITE: begin
                if (mem_ready) begin
                    write_ack_s = 1'b1;
                    if (last_r) begin
                        next_state_s = ST_IDLE;
                    end else begin
                        next_state_s = ST_FILL;
                    end
                end else begin
                    next_state_s = ST_WRITE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Handshake/status outputs registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_ready_r   <= 1'b0;
            chipselect_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            in_ready_r   <= (next_state_s == ST_FILL);
            chipselect_r <= (next_state_s == ST_WRITE);
            busy_r       <= (next_state_s != ST_IDLE);
            done_r       <= write_ack_s & last_r;
        end
    end

    // Word packing, address counter, word counter and wrap flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lane_r       <= 2'd0;
            last_r       <= 1'b0;
            address_r    <= {ADDR_W{1'b0}};
            byteenable_r <= 4'b0000;
            writedata_r  <= 32'h0000_0000;
            word_count_r <= {CNT_W{1'b0}};
            wrapped_r    <= 1'b0;
        end else if (load_s) begin
            lane_r       <= 2'd0;
            last_r       <= 1'b0;
            address_r    <= start_addr;
            byteenable_r <= 4'b0000;
            writedata_r  <= 32'h0000_0000;
            word_count_r <= {CNT_W{1'b0}};
            wrapped_r    <= 1'b0;
        end else if (accept_s) begin
            writedata_r[BYTE_W*lane_r +: BYTE_W] <= in_data;
            byteenable_r <= byteenable_r | lane_mask(lane_r);
            lane_r       <= lane_r + 2'd1;
            last_r       <= in_eop;
        end else if (write_ack_s) begin
            lane_r       <= 2'd0;
            byteenable_r <= 4'b0000;
            writedata_r  <= 32'h0000_0000;
            address_r    <= address_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            if (address_r == {ADDR_W{1'b1}}) begin
                wrapped_r <= 1'b1;
            end else begin
                wrapped_r <= wrapped_r;
            end
            // Saturate rather than roll over so a huge image never reports a small count.
            if (word_count_r != {CNT_W{1'b1}}) begin
                word_count_r <= word_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                word_count_r <= word_count_r;
            end
        end else begin
            lane_r <= lane_r;
        end
    end

    assign in_ready   = in_ready_r;
    assign address    = address_r;
    assign byteenable = byteenable_r;
    assign chipselect = chipselect_r;
    assign write      = chipselect_r;
    assign writedata  = writedata_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign word_count = word_count_r;
    assign wrapped    = wrapped_r;

endmodule : systema_ram_loader

// File: tb/tb_systema_ram_loader.sv
// Directed self-checking bench for systema_ram_loader.
module tb_systema_ram_loader;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [9:0]  start_addr;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_eop;
    logic        in_ready;
    logic        mem_ready;
    logic [9:0]  address;
    logic [3:0]  byteenable;
    logic        chipselect;
    logic        write;
    logic [31:0] writedata;
    logic        busy;
    logic        done;
    logic [10:0] word_count;
    logic        wrapped;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;

    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic [31:0] wb_q[$];

    systema_ram_loader #(.ADDR_W(10), .CNT_W(11)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .start_addr (start_addr),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_eop     (in_eop),
        .in_ready   (in_ready),
        .mem_ready  (mem_ready),
        .address    (address),
        .byteenable (byteenable),
        .chipselect (chipselect),
        .write      (write),
        .writedata  (writedata),
        .busy       (busy),
        .done       (done),
        .word_count (word_count),
        .wrapped    (wrapped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every write the RAM would accept.
    always @(posedge clk) begin
        if (reset_n && chipselect && mem_ready) begin
            wa_q.push_back({22'd0, address});
            wd_q.push_back(writedata);
            wb_q.push_back({28'd0, byteenable});
        end
    end

    // Count done pulses.
    always @(negedge clk) begin
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_write(input string tag, input int idx,
                               input logic [31:0] a, input logic [31:0] d, input logic [31:0] b);
        logic [31:0] oa, od, ob;
        oa = 32'hxxxx_xxxx; od = 32'hxxxx_xxxx; ob = 32'hxxxx_xxxx;
        if (idx < wa_q.size()) begin
            oa = wa_q[idx]; od = wd_q[idx]; ob = wb_q[idx];
        end
        check({tag, "_addr"}, oa, a);
        check({tag, "_data"}, od, d);
        check({tag, "_be"},   ob, b);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_in_ready"},   {31'd0, in_ready},   32'd0);
        check({tag, "_address"},    {22'd0, address},    32'd0);
        check({tag, "_byteenable"}, {28'd0, byteenable}, 32'd0);
        check({tag, "_chipselect"}, {31'd0, chipselect}, 32'd0);
        check({tag, "_write"},      {31'd0, write},      32'd0);
        check({tag, "_writedata"},  writedata,           32'd0);
        check({tag, "_busy"},       {31'd0, busy},       32'd0);
        check({tag, "_done"},       {31'd0, done},       32'd0);
        check({tag, "_word_count"}, {21'd0, word_count}, 32'd0);
        check({tag, "_wrapped"},    {31'd0, wrapped},    32'd0);
    endtask

    task automatic clear_log();
        wa_q.delete(); wd_q.delete(); wb_q.delete();
    endtask

    // Called at a negedge; pulses start for one cycle.
    task automatic do_start(input logic [9:0] a);
        start = 1'b1; start_addr = a;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; holds the byte until accepted, returns at the negedge after.
    task automatic send_byte(input logic [7:0] d, input logic e);
        int n;
        n = 0;
        in_data = d; in_valid = 1'b1; in_eop = e;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("byte_accept_timeout", {31'd0, (n < 100)}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0; in_eop = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; start_addr = 10'd0;
        in_data = 8'd0; in_valid = 1'b0; in_eop = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        check_zero_outputs("rst_hold");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_zero_outputs("rst_rel");

        // Load 1: 8 bytes at 0x010.
        clear_log();
        do_start(10'h010);
        check("l1_busy", {31'd0, busy}, 32'd1);
        check("l1_in_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 1; i <= 8; i++) send_byte(8'(i), (i == 8));
        wait_done();
        check("l1_nwrites", wa_q.size(), 32'd2);
        check_write("l1_w0", 0, 32'h010, 32'h0403_0201, 32'hF);
        check_write("l1_w1", 1, 32'h011, 32'h0807_0605, 32'hF);
        check("l1_word_count", {21'd0, word_count}, 32'd2);
        check("l1_wrapped", {31'd0, wrapped}, 32'd0);
        check("l1_busy_low", {31'd0, busy}, 32'd0);

        // Load 2 started in the done cycle: 6 bytes, partial last word.
        clear_log();
        do_start(10'h020);
        check("l1_done_pulse_end", {31'd0, done}, 32'd0);
        check("l1_done_count", done_cnt, 32'd1);
        check("l2_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 6; i++) send_byte(8'hA0 + 8'(i), (i == 5));
        wait_done();
        check("l2_nwrites", wa_q.size(), 32'd2);
        check_write("l2_w0", 0, 32'h020, 32'hA3A2_A1A0, 32'hF);
        check_write("l2_w1", 1, 32'h021, 32'h0000_A5A4, 32'h3);
        check("l2_word_count", {21'd0, word_count}, 32'd2);
        @(negedge clk);

        // Load 3: address wrap from 0x3FF to 0x000.
        clear_log();
        do_start(10'h3FF);
        for (int i = 0; i < 8; i++) send_byte(8'h11 + 8'(i), (i == 7));
        wait_done();
        check("l3_nwrites", wa_q.size(), 32'd2);
        check_write("l3_w0", 0, 32'h3FF, 32'h1413_1211, 32'hF);
        check_write("l3_w1", 1, 32'h000, 32'h1817_1615, 32'hF);
        check("l3_wrapped", {31'd0, wrapped}, 32'd1);
        @(negedge clk);
        check("l3_wrapped_sticky", {31'd0, wrapped}, 32'd1);

        // Load 4: RAM stalls the first write for 3 cycles.
        clear_log();
        do_start(10'h100);
        check("l4_wrapped_cleared", {31'd0, wrapped}, 32'd0);
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(8'hB0 + 8'(i), 1'b0);
        in_data = 8'hB4; in_valid = 1'b1; in_eop = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("l4_stall_cs",    {31'd0, chipselect}, 32'd1);
            check("l4_stall_write", {31'd0, write},      32'd1);
            check("l4_stall_rdy",   {31'd0, in_ready},   32'd0);
            check("l4_stall_addr",  {22'd0, address},    32'h100);
            check("l4_stall_data",  writedata,           32'hB3B2_B1B0);
            check("l4_stall_be",    {28'd0, byteenable}, 32'hF);
            check("l4_stall_nw",    wa_q.size(),         32'd0);
            @(negedge clk);
        end
        mem_ready = 1'b1;
        for (int i = 4; i < 8; i++) send_byte(8'hB0 + 8'(i), (i == 7));
        wait_done();
        check("l4_nwrites", wa_q.size(), 32'd2);
        check_write("l4_w0", 0, 32'h100, 32'hB3B2_B1B0, 32'hF);
        check_write("l4_w1", 1, 32'h101, 32'hB7B6_B5B4, 32'hF);
        @(negedge clk);

        // Load 5: start while busy is ignored.
        clear_log();
        do_start(10'h040);
        send_byte(8'hC0, 1'b0);
        send_byte(8'hC1, 1'b0);
        do_start(10'h200);
        check("l5_busy", {31'd0, busy}, 32'd1);
        check("l5_addr_kept", {22'd0, address}, 32'h040);
        for (int i = 2; i < 8; i++) send_byte(8'hC0 + 8'(i), (i == 7));
        wait_done();
        check("l5_nwrites", wa_q.size(), 32'd2);
        check_write("l5_w0", 0, 32'h040, 32'hC3C2_C1C0, 32'hF);
        check_write("l5_w1", 1, 32'h041, 32'hC7C6_C5C4, 32'hF);
        @(negedge clk);

        // Load 6: reset mid-load, then a clean load with a 1-byte tail.
        clear_log();
        do_start(10'h080);
        send_byte(8'hE0, 1'b0);
        send_byte(8'hE1, 1'b0);
        reset_n = 1'b0;
        #1;
        check_zero_outputs("midrst");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("midrst_nwrites", wa_q.size(), 32'd0);
        do_start(10'h0C0);
        for (int i = 0; i < 5; i++) send_byte(8'hD0 + 8'(i), (i == 4));
        wait_done();
        check("l6_nwrites", wa_q.size(), 32'd2);
        check_write("l6_w0", 0, 32'h0C0, 32'hD3D2_D1D0, 32'hF);
        check_write("l6_w1", 1, 32'h0C1, 32'h0000_00D4, 32'h1);
        check("l6_word_count", {21'd0, word_count}, 32'd2);
        @(negedge clk);
        check("total_done_count", done_cnt, 32'd6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_systema_ram_loader
